// File: rtl/mem_lsu_ctrl.sv
// MEM-stage load/store sequencer: issues one bus transaction per EX_MEM access,
// stalls the pipeline while it is in flight and returns aligned, extended load data.
module mem_lsu_ctrl #(
  parameter int XLEN = 64,
  parameter int AW   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ls_valid_i,
  input  logic              ls_we_i,
  input  logic [1:0]        ls_size_i,
  input  logic              ls_unsigned_i,
  input  logic [AW-1:0]     ls_addr_i,
  input  logic [XLEN-1:0]   ls_wdata_i,
  input  logic [5:0]        stall_i,
  input  logic [5:0]        flush_i,
  output logic              req_valid_o,
  input  logic              req_ready_i,
  output logic              req_we_o,
  output logic [AW-1:0]     req_addr_o,
  output logic [XLEN-1:0]   req_wdata_o,
  output logic [XLEN/8-1:0] req_wstrb_o,
  input  logic              rsp_valid_i,
  input  logic [XLEN-1:0]   rsp_rdata_i,
  output logic              ram_stall_valid_mem_o,
  output logic [XLEN-1:0]   ldata_o,
  output logic              ldata_valid_o,
  output logic              misalign_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t            state, next_state;
  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [2:0]        off_q;
  logic              killed;
  logic [2:0]        align_mask;
  logic              misaligned;
  logic              accept;
  logic [XLEN/8-1:0] base_strb;
  logic [XLEN-1:0]   rdata_shifted;
  logic [XLEN-1:0]   load_ext;
  logic              sign_bit;
  logic              unused_ctrl;

  // Only the EX_MEM entries of the stall/flush vectors matter here.
  assign unused_ctrl = ^{stall_i[5], stall_i[3:0], flush_i[5], flush_i[3:0]};

  always_comb begin
    align_mask = 3'b000;
    base_strb  = '0;
    case (ls_size_i)
      2'd0: begin align_mask = 3'b000; base_strb = (XLEN/8)'(8'h01); end
      2'd1: begin align_mask = 3'b001; base_strb = (XLEN/8)'(8'h03); end
      2'd2: begin align_mask = 3'b011; base_strb = (XLEN/8)'(8'h0f); end
      default: begin align_mask = 3'b111; base_strb = (XLEN/8)'(8'hff); end
    endcase
  end

  assign misaligned = |(ls_addr_i[2:0] & align_mask);
  assign accept     = (state == IDLE) && ls_valid_i && !misaligned && !flush_i[4];

  always_comb begin
    rdata_shifted = rsp_rdata_i >> {off_q, 3'b000};
    sign_bit      = 1'b0;
    load_ext      = rdata_shifted;
    case (size_q)
      2'd0: begin
        sign_bit = !uns_q && rdata_shifted[7];
        load_ext = {{(XLEN-8){sign_bit}}, rdata_shifted[7:0]};
      end
      2'd1: begin
        sign_bit = !uns_q && rdata_shifted[15];
        load_ext = {{(XLEN-16){sign_bit}}, rdata_shifted[15:0]};
      end
      2'd2: begin
        sign_bit = !uns_q && rdata_shifted[31];
        load_ext = {{(XLEN-32){sign_bit}}, rdata_shifted[31:0]};
      end
      default: load_ext = rdata_shifted;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (accept) next_state = REQ;
      REQ:  if (req_ready_i) next_state = WAIT;
      WAIT: if (rsp_valid_i) next_state = DONE;
      // A killed access leaves immediately; a live one waits for the pipeline to advance.
      DONE: if (killed || !stall_i[4]) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    req_valid_o           = (state == REQ);
    ram_stall_valid_mem_o = accept || (state == REQ) || (state == WAIT);
    ldata_valid_o         = (state == DONE) && !killed && !we_q;
    misalign_o            = (state == IDLE) && ls_valid_i && misaligned;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q        <= 1'b0;
      size_q      <= 2'd0;
      uns_q       <= 1'b0;
      off_q       <= 3'd0;
      killed      <= 1'b0;
      req_we_o    <= 1'b0;
      req_addr_o  <= '0;
      req_wdata_o <= '0;
      req_wstrb_o <= '0;
      ldata_o     <= '0;
    end else begin
      if (accept) begin
        we_q        <= ls_we_i;
        size_q      <= ls_size_i;
        uns_q       <= ls_unsigned_i;
        off_q       <= ls_addr_i[2:0];
        req_we_o    <= ls_we_i;
        req_addr_o  <= {ls_addr_i[AW-1:3], 3'b000};
        req_wdata_o <= ls_wdata_i << {ls_addr_i[2:0], 3'b000};
        req_wstrb_o <= base_strb << ls_addr_i[2:0];
      end
      if (state == WAIT && rsp_valid_i && !we_q) ldata_o <= load_ext;
      if (state == DONE)
        killed <= 1'b0;
      else if ((state == REQ || state == WAIT) && flush_i[4])
        killed <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_lsu_ctrl.sv
// Directed bench for mem_lsu_ctrl: a vector table of single accesses plus
// hand-written sequences for DONE stall, flush, early response and reset.
module tb_mem_lsu_ctrl;

  logic        clk;
  logic        rst_n;
  logic        ls_valid_i;
  logic        ls_we_i;
  logic [1:0]  ls_size_i;
  logic        ls_unsigned_i;
  logic [31:0] ls_addr_i;
  logic [63:0] ls_wdata_i;
  logic [5:0]  stall_i;
  logic [5:0]  flush_i;
  logic        req_valid_o;
  logic        req_ready_i;
  logic        req_we_o;
  logic [31:0] req_addr_o;
  logic [63:0] req_wdata_o;
  logic [7:0]  req_wstrb_o;
  logic        rsp_valid_i;
  logic [63:0] rsp_rdata_i;
  logic        ram_stall_valid_mem_o;
  logic [63:0] ldata_o;
  logic        ldata_valid_o;
  logic        misalign_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        mis;
    logic [31:0] exp_addr;
    logic [7:0]  exp_strb;
    logic [63:0] exp_wdata;
    logic [63:0] exp_ldata;
  } vec_t;

  vec_t vecs[12];

  mem_lsu_ctrl #(.XLEN(64), .AW(32)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .ls_valid_i            (ls_valid_i),
    .ls_we_i               (ls_we_i),
    .ls_size_i             (ls_size_i),
    .ls_unsigned_i         (ls_unsigned_i),
    .ls_addr_i             (ls_addr_i),
    .ls_wdata_i            (ls_wdata_i),
    .stall_i               (stall_i),
    .flush_i               (flush_i),
    .req_valid_o           (req_valid_o),
    .req_ready_i           (req_ready_i),
    .req_we_o              (req_we_o),
    .req_addr_o            (req_addr_o),
    .req_wdata_o           (req_wdata_o),
    .req_wstrb_o           (req_wstrb_o),
    .rsp_valid_i           (rsp_valid_i),
    .rsp_rdata_i           (rsp_rdata_i),
    .ram_stall_valid_mem_o (ram_stall_valid_mem_o),
    .ldata_o               (ldata_o),
    .ldata_valid_o         (ldata_valid_o),
    .misalign_o            (misalign_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic drive_access(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [63:0] wdata);
    ls_valid_i    = 1'b1;
    ls_we_i       = we;
    ls_size_i     = size;
    ls_unsigned_i = uns;
    ls_addr_i     = addr;
    ls_wdata_i    = wdata;
  endtask

  // One access with earliest ready/response; entered and left at a negedge in IDLE.
  task automatic apply_stimulus(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("v%0d", idx);
    drive_access(v.we, v.size, v.uns, v.addr, v.wdata);
    #1;
    if (v.mis) begin
      check_output({tag, "_misalign"}, 64'(misalign_o), 64'd1);
      check_output({tag, "_stall"}, 64'(ram_stall_valid_mem_o), 64'd0);
      @(posedge clk); @(negedge clk);
      check_output({tag, "_no_req"}, 64'(req_valid_o), 64'd0);
      check_output({tag, "_no_stall2"}, 64'(ram_stall_valid_mem_o), 64'd0);
      ls_valid_i = 1'b0;
      return;
    end
    check_output({tag, "_accept_stall"}, 64'(ram_stall_valid_mem_o), 64'd1);
    @(posedge clk); @(negedge clk);
    check_output({tag, "_req_valid"}, 64'(req_valid_o), 64'd1);
    check_output({tag, "_req_we"}, 64'(req_we_o), 64'(v.we));
    check_output({tag, "_req_addr"}, 64'(req_addr_o), 64'(v.exp_addr));
    check_output({tag, "_req_wstrb"}, 64'(req_wstrb_o), 64'(v.exp_strb));
    check_output({tag, "_req_wdata"}, req_wdata_o, v.exp_wdata);
    req_ready_i = 1'b1;
    @(posedge clk); @(negedge clk);
    req_ready_i = 1'b0;
    check_output({tag, "_wait_req_low"}, 64'(req_valid_o), 64'd0);
    check_output({tag, "_wait_stall"}, 64'(ram_stall_valid_mem_o), 64'd1);
    rsp_valid_i = 1'b1;
    rsp_rdata_i = v.rdata;
    @(posedge clk); @(negedge clk);
    rsp_valid_i = 1'b0;
    check_output({tag, "_done_stall"}, 64'(ram_stall_valid_mem_o), 64'd0);
    check_output({tag, "_ldata_valid"}, 64'(ldata_valid_o), 64'(!v.we));
    if (!v.we) check_output({tag, "_ldata"}, ldata_o, v.exp_ldata);
    ls_valid_i = 1'b0;
    @(posedge clk); @(negedge clk);
    check_output({tag, "_idle_valid_low"}, 64'(ldata_valid_o), 64'd0);
  endtask

  initial begin
    //            we    sz    uns   addr           wdata                  rdata                  mis   exp_addr       strb   exp_wdata              exp_ldata
    vecs[0]  = '{1'b0, 2'd2, 1'b0, 32'h8000_0004, 64'h0,                 64'h8765_4321_1234_5678, 1'b0, 32'h8000_0000, 8'hF0, 64'h0,                 64'hFFFF_FFFF_8765_4321};
    vecs[1]  = '{1'b1, 2'd0, 1'b0, 32'h8000_0003, 64'h0000_0000_0000_00AB, 64'h0,               1'b0, 32'h8000_0000, 8'h08, 64'h0000_0000_AB00_0000, 64'h0};
    vecs[2]  = '{1'b0, 2'd0, 1'b0, 32'h8000_0007, 64'h0,                 64'h8011_2233_4455_6677, 1'b0, 32'h8000_0000, 8'h80, 64'h0,                 64'hFFFF_FFFF_FFFF_FF80};
    vecs[3]  = '{1'b0, 2'd0, 1'b1, 32'h8000_0007, 64'h0,                 64'h8011_2233_4455_6677, 1'b0, 32'h8000_0000, 8'h80, 64'h0,                 64'h0000_0000_0000_0080};
    vecs[4]  = '{1'b0, 2'd1, 1'b0, 32'h1000_0002, 64'h0,                 64'h1122_3344_F001_9988, 1'b0, 32'h1000_0000, 8'h0C, 64'h0,                 64'hFFFF_FFFF_FFFF_F001};
    vecs[5]  = '{1'b0, 2'd3, 1'b1, 32'h1000_0008, 64'h0,                 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 32'h1000_0008, 8'hFF, 64'h0,                 64'hDEAD_BEEF_CAFE_F00D};
    vecs[6]  = '{1'b1, 2'd1, 1'b0, 32'h2000_000E, 64'h0000_0000_0000_1234, 64'h0,               1'b0, 32'h2000_0008, 8'hC0, 64'h1234_0000_0000_0000, 64'h0};
    vecs[7]  = '{1'b1, 2'd3, 1'b0, 32'h2000_0010, 64'h0102_0304_0506_0708, 64'h0,               1'b0, 32'h2000_0010, 8'hFF, 64'h0102_0304_0506_0708, 64'h0};
    vecs[8]  = '{1'b0, 2'd2, 1'b1, 32'h0000_0000, 64'h0,                 64'h0000_0000_FFFF_FFFE, 1'b0, 32'h0000_0000, 8'h0F, 64'h0,                 64'h0000_0000_FFFF_FFFE};
    vecs[9]  = '{1'b0, 2'd1, 1'b0, 32'h8000_0001, 64'h0,                 64'h0,                 1'b1, 32'h0,         8'h00, 64'h0,                 64'h0};
    vecs[10] = '{1'b0, 2'd2, 1'b0, 32'h8000_0006, 64'h0,                 64'h0,                 1'b1, 32'h0,         8'h00, 64'h0,                 64'h0};
    vecs[11] = '{1'b1, 2'd3, 1'b0, 32'h8000_0004, 64'h0,                 64'h0,                 1'b1, 32'h0,         8'h00, 64'h0,                 64'h0};

    rst_n = 1'b0;
    ls_valid_i = 1'b0; ls_we_i = 1'b0; ls_size_i = 2'd0; ls_unsigned_i = 1'b0;
    ls_addr_i = '0; ls_wdata_i = '0; stall_i = '0; flush_i = '0;
    req_ready_i = 1'b0; rsp_valid_i = 1'b0; rsp_rdata_i = '0;
    #1;
    check_output("rst_req_valid", 64'(req_valid_o), 64'd0);
    check_output("rst_req_we", 64'(req_we_o), 64'd0);
    check_output("rst_req_addr", 64'(req_addr_o), 64'd0);
    check_output("rst_req_wdata", req_wdata_o, 64'd0);
    check_output("rst_req_wstrb", 64'(req_wstrb_o), 64'd0);
    check_output("rst_ldata", ldata_o, 64'd0);
    check_output("rst_ldata_valid", 64'(ldata_valid_o), 64'd0);
    check_output("rst_stall", 64'(ram_stall_valid_mem_o), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) apply_stimulus(vecs[i], i);

    // Pipeline holds EX_MEM for three cycles after the load completes.
    drive_access(1'b0, 2'd2, 1'b0, 32'h0000_0100, 64'h0);
    @(posedge clk); @(negedge clk);
    req_ready_i = 1'b1;
    @(posedge clk); @(negedge clk);
    req_ready_i = 1'b0; rsp_valid_i = 1'b1; rsp_rdata_i = 64'h0000_0000_7FFF_0001;
    @(posedge clk); @(negedge clk);
    rsp_valid_i = 1'b0; stall_i = 6'b01_0000;
    for (int c = 0; c < 3; c++) begin
      check_output($sformatf("hold%0d_ldata_valid", c), 64'(ldata_valid_o), 64'd1);
      check_output($sformatf("hold%0d_ldata", c), ldata_o, 64'h0000_0000_7FFF_0001);
      check_output($sformatf("hold%0d_no_reissue", c), 64'(req_valid_o), 64'd0);
      check_output($sformatf("hold%0d_stall", c), 64'(ram_stall_valid_mem_o), 64'd0);
      @(posedge clk); @(negedge clk);
    end
    stall_i = '0; ls_valid_i = 1'b0;
    @(posedge clk); @(negedge clk);
    check_output("hold_release_valid", 64'(ldata_valid_o), 64'd0);
    check_output("hold_release_req", 64'(req_valid_o), 64'd0);
    check_output("hold_release_ldata", ldata_o, 64'h0000_0000_7FFF_0001);

    // Flush pulse in WAIT: the beat still completes but nothing is delivered.
    drive_access(1'b0, 2'd3, 1'b0, 32'h0000_0200, 64'h0);
    @(posedge clk); @(negedge clk);
    req_ready_i = 1'b1;
    @(posedge clk); @(negedge clk);
    req_ready_i = 1'b0; flush_i = 6'b01_0000;
    @(posedge clk); @(negedge clk);
    flush_i = '0;
    check_output("flush_wait_stall", 64'(ram_stall_valid_mem_o), 64'd1);
    rsp_valid_i = 1'b1; rsp_rdata_i = 64'h55;
    @(posedge clk); @(negedge clk);
    rsp_valid_i = 1'b0; stall_i = 6'b01_0000;
    check_output("flush_done_valid", 64'(ldata_valid_o), 64'd0);
    check_output("flush_done_stall", 64'(ram_stall_valid_mem_o), 64'd0);
    @(posedge clk); @(negedge clk);
    check_output("flush_back_idle", 64'(ram_stall_valid_mem_o), 64'd1);
    check_output("flush_idle_valid", 64'(ldata_valid_o), 64'd0);
    ls_valid_i = 1'b0; stall_i = '0;
    @(posedge clk); @(negedge clk);
    check_output("flush_no_req", 64'(req_valid_o), 64'd0);

    // Response coinciding with ready in REQ must be ignored.
    drive_access(1'b0, 2'd1, 1'b1, 32'h0000_0306, 64'h0);
    @(posedge clk); @(negedge clk);
    req_ready_i = 1'b1; rsp_valid_i = 1'b1; rsp_rdata_i = 64'h1111_0000_0000_0000;
    @(posedge clk); @(negedge clk);
    req_ready_i = 1'b0; rsp_valid_i = 1'b0;
    check_output("early_rsp_still_wait", 64'(ram_stall_valid_mem_o), 64'd1);
    check_output("early_rsp_no_valid", 64'(ldata_valid_o), 64'd0);
    @(posedge clk); @(negedge clk);
    check_output("early_rsp_wait2", 64'(ram_stall_valid_mem_o), 64'd1);
    rsp_valid_i = 1'b1; rsp_rdata_i = 64'hBEEF_0000_0000_0000;
    @(posedge clk); @(negedge clk);
    rsp_valid_i = 1'b0;
    check_output("early_rsp_valid", 64'(ldata_valid_o), 64'd1);
    check_output("early_rsp_ldata", ldata_o, 64'h0000_0000_0000_BEEF);
    ls_valid_i = 1'b0;
    @(posedge clk); @(negedge clk);

    // Asynchronous reset while a store request is outstanding.
    drive_access(1'b1, 2'd3, 1'b0, 32'h0000_0400, 64'h1111);
    @(posedge clk); @(negedge clk);
    check_output("rreq_valid_before", 64'(req_valid_o), 64'd1);
    rst_n = 1'b0; ls_valid_i = 1'b0;
    #1;
    check_output("rreq_valid_now", 64'(req_valid_o), 64'd0);
    check_output("rreq_stall_now", 64'(ram_stall_valid_mem_o), 64'd0);
    check_output("rreq_we_now", 64'(req_we_o), 64'd0);
    check_output("rreq_addr_now", 64'(req_addr_o), 64'd0);
    check_output("rreq_wstrb_now", 64'(req_wstrb_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    check_output("rreq_idle_after", 64'(req_valid_o), 64'd0);
    apply_stimulus(vecs[0], 100);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mem_lsu_ctrl.md
Name: mem_lsu_ctrl

Overview:
- MEM-stage load/store sequencer.
- Turns the EX_MEM load/store request into a single bus transaction toward the memory arbiter.
- Drives the MEM-stage RAM stall request consumed by the pipeline controller, and returns aligned, extended load data to MEM_WB.
- Holds each completed access until the pipeline advances, so a stalled instruction never issues twice.

Parameters:
- XLEN, 64, data width in bits.
- AW, 32, address width in bits.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- ls_valid_i  in  1  a load/store is present in MEM.
- ls_we_i  in  1  1 = store, 0 = load.
- ls_size_i  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = double.
- ls_unsigned_i  in  1  zero-extend the load.
- ls_addr_i  in  AW  byte address.
- ls_wdata_i  in  XLEN  store data, LSB-justified.
- stall_i  in  6  pipeline stall vector; bit4 = EX_MEM.
- flush_i  in  6  pipeline flush vector; bit4 = EX_MEM.
- req_valid_o  out  1  bus request.
- req_ready_i  in  1  arbiter accepts the request.
- req_we_o  out  1  write request.
- req_addr_o  out  AW  address aligned down to 8 bytes.
- req_wdata_o  out  XLEN  store data shifted to byte lane.
- req_wstrb_o  out  XLEN/8  byte strobes.
- rsp_valid_i  in  1  read data returned, or write acknowledged.
- rsp_rdata_i  in  XLEN  read data, 8-byte aligned.
- ram_stall_valid_mem_o  out  1  stall request to the pipeline controller.
- ldata_o  out  XLEN  extended load result.
- ldata_valid_o  out  1  ldata_o is valid for MEM_WB.
- misalign_o  out  1  misaligned access detected; no bus activity.

Behaviour:
- States: IDLE, REQ, WAIT, DONE. All state, request and data registers reset asynchronously when rst_n = 0.
- Reset values: state = IDLE, req_valid_o = 0, req_we_o = 0, req_addr_o = 0, req_wdata_o = 0, req_wstrb_o = 0, ldata_o = 0, ldata_valid_o = 0, killed = 0.
- Misaligned: (addr & ((1 << size) - 1)) != 0.
  - misalign_o = ls_valid_i & misaligned in IDLE (combinational).
  - No transition and no stall.
- IDLE, ls_valid_i & !misaligned & !flush_i[4]:
  - Latch we, size, unsigned, addr[2:0], shifted wdata and strobes.
  - Next state REQ.
  - ram_stall_valid_mem_o = 1 in this same cycle (combinational).
- Strobes: the base mask is 1, 3, 15 or 255 for size 0–3, shifted left by addr[2:0]. wdata is shifted left by addr[2:0] × 8.
- REQ:
  - req_valid_o = 1, with all req_* fields stable until req_ready_i.
  - On req_ready_i, next state is WAIT and req_valid_o deasserts next cycle.
- WAIT:
  - Wait for rsp_valid_i, then go to DONE.
  - For a load, register ldata_o = rsp_rdata_i >> (addr[2:0] × 8), truncated to size and then sign- or zero-extended to XLEN. Size 3 ignores ls_unsigned_i.
  - For a store, ldata_o is unchanged.
- ram_stall_valid_mem_o = 1 in REQ and WAIT, and in IDLE on an accepted access. It is 0 in DONE.
- DONE:
  - ldata_valid_o = !killed & !we.
  - If stall_i[4] = 0, the pipeline advances and the next state is IDLE.
  - Otherwise the unit stays in DONE with ldata held and no re-issue, even though ls_valid_i remains 1.
- Flush: flush_i[4] = 1 in REQ or WAIT sets killed.
  - The bus transaction still completes; it is never abandoned mid-handshake.
  - Once in DONE, ldata_valid_o = 0 and the unit returns to IDLE on the next cycle regardless of stall_i.
  - killed clears on leaving DONE.
- rsp_valid_i outside WAIT is ignored.
- req_ready_i together with rsp_valid_i in REQ: only req_ready_i is honoured; the response is expected in WAIT.
- Reset mid-transaction: outputs return to reset values immediately (asynchronous). The arbiter must drop any outstanding beat on its own reset.
- Throughput: at least 1 idle cycle between accesses. Minimum load latency is 3 cycles from acceptance to ldata_valid_o when req_ready_i and rsp_valid_i arrive at the earliest opportunity.

Test Plan:
- Load word, unsigned = 0, addr 0x80000004, rdata 0x8765432112345678, ready and rsp each after 1 cycle:
  - Stall high from the accept cycle until DONE.
  - ldata_o = 0xFFFFFFFF87654321.
  - ldata_valid_o for 1 cycle.
- Store byte 0xAB at addr 0x80000003:
  - req_addr_o = 0x80000000.
  - req_wstrb_o = 0x08.
  - req_wdata_o[31:24] = 0xAB.
  - req_we_o = 1.
  - ldata_valid_o stays 0.
- Load completes while stall_i[4] is held 1 for 3 cycles:
  - Unit stays in DONE with ldata stable.
  - req_valid_o stays 0 (no second request).
  - Unit returns to IDLE when stall_i[4] falls.
- flush_i[4] pulsed while in WAIT, then rsp_valid_i arrives:
  - Transaction completes.
  - ldata_valid_o = 0.
  - Unit returns to IDLE the following cycle.
- Half load at addr 0x80000001:
  - misalign_o = 1.
  - req_valid_o = 0.
  - ram_stall_valid_mem_o = 0.
- rst_n dropped while in REQ:
  - req_valid_o and ram_stall_valid_mem_o go 0 immediately.
  - State is IDLE after release.
